// File: rtl/credit_sender.sv
// credit_sender: transmit-side endpoint of a credit-based link.
//
// Accepts words from an upstream valid/ready source and forwards each one to
// a downstream capacity queue as a one-cycle valid pulse. Each send consumes
// one credit. The receiver returns one credit pulse per dequeue, so the local
// credit count mirrors the queue's free capacity and the queue is never
// overrun.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   data_in       upstream data word
//   valid_in      upstream word valid
//   ready_in      block can accept a word this cycle (decoded from state only)
//   data_out      registered word toward the queue's enq data input
//   valid_out     one-cycle send pulse, drives the queue's enq
//   credit_in     one-cycle credit return pulse from the receiver's deq
//   credits       current credit count
//   stall         high while credits are exhausted
//   overflow_err  sticky: a credit came back while credits == DEPTH
module credit_sender #(
    parameter int unsigned  WIDTH = 1,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             credit_in,
    output logic [CW-1:0]    credits,
    output logic             stall,
    output logic             overflow_err
);

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StEmpty
    } state_e;

    localparam logic [CW-1:0] FullCredits = CW'(DEPTH);

    state_e        state;
    logic          send;
    logic          credit_ret;
    logic          overflow_hit;
    logic [CW-1:0] credits_next;

    // Handshake outputs come straight from the state register, so neither
    // valid_in nor credit_in can reach ready_in combinationally.
    assign ready_in = (state == StRun);
    assign stall    = (state == StEmpty);

    assign send = valid_in & ready_in;

    // Credits are not yet loaded in INIT; a return there is meaningless.
    assign credit_ret = credit_in & (state != StInit);

    always_comb begin
        credits_next = credits;
        overflow_hit = 1'b0;
        if (send && !credit_ret) begin
            credits_next = credits - 1'b1;
        end else if (!send && credit_ret) begin
            if (credits == FullCredits) begin
                overflow_hit = 1'b1;  // saturate and flag
            end else begin
                credits_next = credits + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StInit;
            credits      <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            overflow_err <= 1'b0;
        end else begin
            valid_out <= send;
            if (send) begin
                data_out <= data_in;
            end
            if (overflow_hit) begin
                overflow_err <= 1'b1;
            end
            case (state)
                StInit: begin
                    credits <= FullCredits;
                    state   <= StRun;
                end
                default: begin
                    credits <= credits_next;
                    state   <= (credits_next == '0) ? StEmpty : StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_credit_sender.sv
// Self-checking bench for credit_sender (WIDTH=1, DEPTH=4).
// A table of per-cycle input/expected-output records drives the main flow;
// a scoreboard queue tracks accepted words and checks them on valid_out.
// Hand-written sequences cover reset behaviour, including reset mid-pulse.
module tb_credit_sender;

    localparam int WIDTH = 1;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             credit_in;
    logic [CW-1:0]    credits;
    logic             stall;
    logic             overflow_err;

    int total = 0;
    int bad   = 0;
    int occ   = 0;              // words held downstream (sent, not yet returned)
    logic [WIDTH-1:0] sb_q[$];  // words accepted, awaiting valid_out

    typedef struct {
        logic v;
        logic d;
        logic c;
        logic exp_vo;
        int   exp_cr;
        logic exp_rdy;
        logic exp_st;
        logic exp_ovf;
    } vec_t;

    vec_t vecs[20];

    credit_sender #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .credit_in    (credit_in),
        .credits      (credits),
        .stall        (stall),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Apply one cycle of inputs, record any accepted word, then sample #1
    // after the edge and reconcile valid_out against the scoreboard.
    task automatic step(input logic v, input logic d, input logic c);
        valid_in  = v;
        data_in   = d;
        credit_in = c;
        #1;
        if (v && ready_in) begin
            sb_q.push_back(d);
            occ++;
        end
        if (c && occ > 0) occ--;
        @(posedge clk);
        #1;
        if (valid_out) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid_out", 1, 0);
            end else begin
                check("sb_data_out", int'(data_out), int'(sb_q.pop_front()));
            end
        end else if (sb_q.size() != 0) begin
            check("sb_missing_valid_out", 0, 1);
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v     d     c     vo    cr  rdy   st    ovf
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0}; // INIT: credit ignored
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0}; // -> EMPTY
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0}; // valid ignored
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0}; // EMPTY -> RUN
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0}; // back to EMPTY
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0}; // send + credit
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1}; // overflow
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1}; // sticky
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b1}; // full, send + credit
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1};

        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        credit_in = 1'b0;

        // Reset held across an edge.
        #12;
        check("rst_credits", int'(credits), 0);
        check("rst_ready_in", int'(ready_in), 0);
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_overflow_err", int'(overflow_err), 0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("init_ready_in", int'(ready_in), 0);
        check("init_credits", int'(credits), 0);

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].c);
            check($sformatf("v%0d_valid_out", i), int'(valid_out), int'(vecs[i].exp_vo));
            check($sformatf("v%0d_credits", i), int'(credits), vecs[i].exp_cr);
            check($sformatf("v%0d_ready_in", i), int'(ready_in), int'(vecs[i].exp_rdy));
            check($sformatf("v%0d_stall", i), int'(stall), int'(vecs[i].exp_st));
            check($sformatf("v%0d_overflow_err", i), int'(overflow_err), int'(vecs[i].exp_ovf));
            check($sformatf("v%0d_invariant", i), int'(credits) + occ, DEPTH);
        end

        // valid_out is high with credits=1 here; reset must clear it at once.
        valid_in  = 1'b0;
        credit_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_valid_out", int'(valid_out), 0);
        check("async_data_out", int'(data_out), 0);
        check("async_credits", int'(credits), 0);
        check("async_ready_in", int'(ready_in), 0);
        check("async_overflow_err", int'(overflow_err), 0);
        sb_q.delete();
        occ = 0;

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_init_credits", int'(credits), 0);
        check("rel_init_ready_in", int'(ready_in), 0);
        @(posedge clk);
        #1;
        check("rel_run_credits", int'(credits), DEPTH);
        check("rel_run_ready_in", int'(ready_in), 1);

        // One send after recovery, carried through the scoreboard.
        step(1'b1, 1'b1, 1'b0);
        check("post_valid_out", int'(valid_out), 1);
        check("post_credits", int'(credits), DEPTH - 1);
        step(1'b0, 1'b0, 1'b0);
        check("post_pulse_len", int'(valid_out), 0);
        check("post_data_hold", int'(data_out), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
